// File: rtl/mest_pro_mm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mest_pro_mm_ctrl_if
//  Brief    : Exec-stage main-memory request/response bundle (exec <-> memory)
//  Revision : 1.0
// ============================================================================
interface mest_pro_mm_ctrl_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8
);
    logic                 mm_select;
    logic                 cs;
    logic                 we;
    logic [ADDR_BITS-1:0] mm_addr;
    logic [DATA_BITS-1:0] mm_dat;
    logic [DATA_BITS-1:0] mm_rdata;
    logic                 mm_ready;
    logic                 mm_busy;
    logic                 mm_err;

    modport master (
        output mm_select,
        output cs,
        output we,
        output mm_addr,
        output mm_dat,
        input  mm_rdata,
        input  mm_ready,
        input  mm_busy,
        input  mm_err
    );

    modport slave (
        input  mm_select,
        input  cs,
        input  we,
        input  mm_addr,
        input  mm_dat,
        output mm_rdata,
        output mm_ready,
        output mm_busy,
        output mm_err
    );
endinterface
`default_nettype wire

// File: rtl/mest_pro_mm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mest_pro_mm_ctrl
//  Brief    : Main-memory responder with fixed wait states and a word array
//  Revision : 1.0
// ============================================================================
module mest_pro_mm_ctrl #(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 8,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  wire logic          clk,
    input  wire logic          i_reset,
    mest_pro_mm_ctrl_if.slave  io_mm
);

    localparam int         c_DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_DRAIN  = 2'd3;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DATA_BITS-1:0]  r_dat;
    logic [DATA_BITS-1:0]  r_rdata;
    logic                  r_ready;
    logic                  r_err;

    logic [DATA_BITS-1:0]  r_mem [c_DEPTH];

    logic                  w_req;
    logic                  w_in_range;
    logic                  w_do_write;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_req = io_mm.mm_select & io_mm.cs;
    assign w_idx = r_addr[DEPTH_LOG2-1:0];

    // Any address bit above the array index makes the access out of range.
    generate
        if (ADDR_BITS > DEPTH_LOG2) begin : g_range_upper
            assign w_in_range = ~|r_addr[ADDR_BITS-1:DEPTH_LOG2];
        end else begin : g_range_full
            assign w_in_range = 1'b1;
        end
    endgenerate

    assign w_do_write = (r_state == c_ACCESS) & r_we & w_in_range;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_we   <= io_mm.we;
                        r_addr <= io_mm.mm_addr;
                        r_dat  <= io_mm.mm_dat;
                        if (WAIT_STATES > 0) begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_WAIT_INIT;
                        end else begin
                            r_state <= c_ACCESS;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= c_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ACCESS: begin
                    r_ready <= 1'b1;
                    r_state <= c_DRAIN;
                    if (w_in_range) begin
                        if (!r_we) begin
                            r_rdata <= r_mem[w_idx];
                        end
                    end else begin
                        r_err <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                    end
                end
                c_DRAIN: begin
                    // Select is a level; wait for it to drop so one request = one access.
                    if (!io_mm.mm_select) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Reset forces IDLE, so a store pending at reset never reaches the array.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_idx] <= r_dat;
        end
    end

    assign io_mm.mm_rdata = r_rdata;
    assign io_mm.mm_ready = r_ready;
    assign io_mm.mm_err   = r_err;
    assign io_mm.mm_busy  = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mest_pro_mm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mest_pro_mm_ctrl
//  Brief    : Self-checking bench: WAIT_STATES=2 and WAIT_STATES=0 responders
//  Revision : 1.0
// ============================================================================
module tb_mest_pro_mm_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel  [2];
    logic        cs   [2];
    logic        wev  [2];
    logic [15:0] addr [2];
    logic [7:0]  dat  [2];
    logic [7:0]  rd   [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        erro [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: plain word store per DUT, plus last-read tracking.
    logic [7:0] mdl        [2][1024];
    bit         vld        [2][1024];
    logic [7:0] last_rd    [2];
    bit         last_known [2];
    int         ws         [2];

    mest_pro_mm_ctrl_if #(.ADDR_BITS(16), .DATA_BITS(8)) if_a ();
    mest_pro_mm_ctrl_if #(.ADDR_BITS(16), .DATA_BITS(8)) if_b ();

    assign if_a.mm_select = sel[0];
    assign if_a.cs        = cs[0];
    assign if_a.we        = wev[0];
    assign if_a.mm_addr   = addr[0];
    assign if_a.mm_dat    = dat[0];
    assign rd[0]          = if_a.mm_rdata;
    assign rdy[0]         = if_a.mm_ready;
    assign busy[0]        = if_a.mm_busy;
    assign erro[0]        = if_a.mm_err;

    assign if_b.mm_select = sel[1];
    assign if_b.cs        = cs[1];
    assign if_b.we        = wev[1];
    assign if_b.mm_addr   = addr[1];
    assign if_b.mm_dat    = dat[1];
    assign rd[1]          = if_b.mm_rdata;
    assign rdy[1]         = if_b.mm_ready;
    assign busy[1]        = if_b.mm_busy;
    assign erro[1]        = if_b.mm_err;

    mest_pro_mm_ctrl #(
        .ADDR_BITS(16), .DATA_BITS(8), .DEPTH_LOG2(10), .WAIT_STATES(2)
    ) u_dut_a (
        .clk    (clk),
        .i_reset(rst),
        .io_mm  (if_a)
    );

    mest_pro_mm_ctrl #(
        .ADDR_BITS(16), .DATA_BITS(8), .DEPTH_LOG2(10), .WAIT_STATES(0)
    ) u_dut_b (
        .clk    (clk),
        .i_reset(rst),
        .io_mm  (if_b)
    );

    // One full request: drive, wait for ready, check, hold select, release.
    task automatic access(input int d, input bit we, input logic [15:0] a,
                          input logic [7:0] wd, input bit corrupt, input int hold,
                          input string tag);
        int         n;
        bit         got;
        int         extra;
        int         nbusy;
        bit         inr;
        bit         exp_err;
        bit         chk_rd;
        logic [7:0] exp_rd;
        logic [9:0] ix;

        ix      = a[9:0];
        inr     = (a < 16'd1024);
        exp_err = !inr;
        chk_rd  = last_known[d];
        exp_rd  = last_rd[d];
        if (we) begin
            if (inr) begin
                mdl[d][ix] = wd;
                vld[d][ix] = 1'b1;
            end
        end else if (inr) begin
            chk_rd = vld[d][ix];
            exp_rd = mdl[d][ix];
        end else begin
            chk_rd = 1'b1;
            exp_rd = 8'h00;
        end
        last_rd[d]    = exp_rd;
        last_known[d] = chk_rd;

        sel[d] = 1'b1; cs[d] = 1'b1; wev[d] = we; addr[d] = a; dat[d] = wd;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (corrupt && n == 1) begin
                addr[d] = a + 16'd1;
                dat[d]  = ~wd;
            end
            if (rdy[d]) got = 1'b1;
        end

        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout dut%0d: no ready after %0d cycles", tag, d, n);
        end else begin
            checks++;
            if (n !== ws[d] + 2) begin
                failures++;
                $display("FAIL %s_latency dut%0d: got %0d edges expected %0d", tag, d, n, ws[d] + 2);
            end
            checks++;
            if (erro[d] !== exp_err) begin
                failures++;
                $display("FAIL %s_err dut%0d: got %b expected %b", tag, d, erro[d], exp_err);
            end
            if (chk_rd) begin
                checks++;
                if (rd[d] !== exp_rd) begin
                    failures++;
                    $display("FAIL %s_rdata dut%0d: got %h expected %h", tag, d, rd[d], exp_rd);
                end
            end
        end

        extra = 0; nbusy = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rdy[d] || erro[d]) extra++;
            if (!busy[d]) nbusy++;
        end
        sel[d] = 1'b0;
        @(posedge clk); #1;
        if (rdy[d] || erro[d]) extra++;
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL %s_pulse dut%0d: got %0d extra ready/err cycles expected 0", tag, d, extra);
        end
        if (hold > 0) begin
            checks++;
            if (nbusy !== 0) begin
                failures++;
                $display("FAIL %s_busy_hold dut%0d: got %0d idle cycles expected 0", tag, d, nbusy);
            end
        end
        checks++;
        if (busy[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_release dut%0d: got %b expected 0", tag, d, busy[d]);
        end
        cs[d] = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd[d] !== 8'h00 || rdy[d] !== 1'b0 || erro[d] !== 1'b0 || busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL %s dut%0d: got rdata=%h ready=%b err=%b busy=%b expected all 0",
                         tag, d, rd[d], rdy[d], erro[d], busy[d]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sel[d] = 1'b0; cs[d] = 1'b0; wev[d] = 1'b0; addr[d] = '0; dat[d] = '0;
            last_rd[d] = 8'h00; last_known[d] = 1'b1;
            for (int i = 0; i < 1024; i++) vld[d][i] = 1'b0;
        end
        sel[0] = 1'b1; cs[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        sel[0] = 1'b0; cs[0] = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        access(0, 1'b1, 16'h0010, 8'hA5, 1'b0, 1, "st10");
        access(0, 1'b0, 16'h0010, 8'h00, 1'b0, 1, "ld10");
    endtask

    task automatic test_hold_select;
        access(0, 1'b1, 16'h0050, 8'h3C, 1'b0, 10, "hold_st");
        access(0, 1'b0, 16'h0050, 8'h00, 1'b0, 10, "hold_ld");
    endtask

    task automatic test_out_of_range;
        access(0, 1'b1, 16'h0000, 8'h9E, 1'b0, 1, "pre0");
        access(0, 1'b1, 16'h0400, 8'h55, 1'b0, 1, "oor_st");
        access(0, 1'b0, 16'h0000, 8'h00, 1'b0, 1, "alias_ld");
        access(0, 1'b0, 16'h0400, 8'h00, 1'b0, 1, "oor_ld");
        access(0, 1'b0, 16'h0000, 8'h00, 1'b0, 1, "alias_ld2");
        access(0, 1'b1, 16'h8001, 8'h66, 1'b0, 1, "oor_hi_st");
        access(0, 1'b0, 16'h0001, 8'h00, 1'b0, 1, "ld1_unk");
    endtask

    task automatic test_latch_ignore;
        access(0, 1'b1, 16'h0021, 8'h4B, 1'b0, 1, "pre21");
        access(0, 1'b1, 16'h0020, 8'h11, 1'b1, 1, "st20_chg");
        access(0, 1'b0, 16'h0020, 8'h00, 1'b0, 1, "ld20");
        access(0, 1'b0, 16'h0021, 8'h00, 1'b0, 1, "ld21");
    endtask

    task automatic test_reset_mid;
        access(0, 1'b1, 16'h0030, 8'h12, 1'b0, 1, "pre30");
        access(0, 1'b0, 16'h0030, 8'h00, 1'b0, 1, "ld30_pre");
        sel[0] = 1'b1; cs[0] = 1'b1; wev[0] = 1'b1; addr[0] = 16'h0030; dat[0] = 8'h77;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid");
        sel[0] = 1'b0; cs[0] = 1'b0;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        last_known[0] = 1'b1; last_known[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b0, 16'h0030, 8'h00, 1'b0, 1, "ld30_post");
    endtask

    task automatic test_random;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                access(d, 1'b1, 16'h0100 + 16'(i), 8'($urandom), 1'b0, 0, "rnd_init");
            end
        end
        for (int i = 0; i < 40; i++) begin
            int          d;
            bit          we;
            logic [15:0] a;
            d  = i % 2;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 16'h0400 | 16'($urandom);
            else                           a = 16'h0100 + 16'($urandom_range(0, 15));
            access(d, we, a, 8'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), "rnd");
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat [4];
        pat[0] = 8'h5A; pat[1] = 8'hC3; pat[2] = 8'h0F; pat[3] = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b1, 16'h0200 + 16'(i), pat[i], 1'b0, 0, "b2b_st");
            access(1, 1'b0, 16'h0200 + 16'(i), 8'h00, 1'b0, 0, "b2b_ld");
        end
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b0, 16'h0200 + 16'(i), 8'h00, 1'b0, 0, "b2b_rb");
        end
        access(1, 1'b0, 16'h0400, 8'h00, 1'b0, 0, "b2b_oor");
    endtask

    initial begin
        ws[0] = 2;
        ws[1] = 0;
        test_reset();
        test_store_load();
        test_hold_select();
        test_out_of_range();
        test_latch_ignore();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
